// File: rtl/fir_mac_ctrl.sv
// FIR controller that time-shares one external multiplier across NTAPS taps.
// One sample in, NTAPS MAC cycles, then a held result until downstream takes it.
module fir_mac_ctrl #(
  parameter int NTAPS = 8,
  parameter int ACC_W = 19,
  localparam int AW = $clog2(NTAPS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic signed [3:0]       in_data,
  output logic                    in_ready,
  input  logic                    coef_we,
  input  logic [AW-1:0]           coef_addr,
  input  logic signed [8:0]       coef_data,
  output logic                    coef_err,
  output logic signed [3:0]       mul_in,
  output logic signed [8:0]       mul_h,
  input  logic signed [15:0]      mul_prod,
  output logic                    out_valid,
  output logic signed [ACC_W-1:0] out_data,
  input  logic                    out_ready
);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);

  state_t                  state;
  logic signed [3:0]       dly  [NTAPS];
  logic signed [8:0]       coef [NTAPS];
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_nxt;
  logic [AW-1:0]           tap;

  assign in_ready = (state == IDLE);
  assign mul_in   = (state == MAC) ? dly[tap]  : '0;
  assign mul_h    = (state == MAC) ? coef[tap] : '0;
  assign acc_nxt  = acc + {{(ACC_W-16){mul_prod[15]}}, mul_prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      tap       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      coef_err  <= 1'b0;
      for (int k = 0; k < NTAPS; k++) begin
        dly[k]  <= '0;
        coef[k] <= '0;
      end
    end else begin
      // writes are only legal while no pass is using the coefficients
      coef_err <= coef_we && (state != IDLE);
      unique case (state)
        IDLE: begin
          if (coef_we)
            coef[coef_addr] <= coef_data;
          if (in_valid) begin
            dly[0] <= in_data;
            for (int k = 1; k < NTAPS; k++)
              dly[k] <= dly[k-1];
            acc   <= '0;
            tap   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc_nxt;
          tap <= tap + AW'(1);
          if (tap == LAST) begin
            out_data  <= acc_nxt;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_ctrl.sv
// Bench for fir_mac_ctrl: transaction-level model plus directed cases.
// Includes a behavioural stand-in for the external shift_mul.
module tb_fir_mac_ctrl;
  localparam int NTAPS = 8;
  localparam int ACC_W = 19;
  localparam int AW = 3;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic signed [3:0]       in_data = '0;
  logic                    in_ready;
  logic                    coef_we = 1'b0;
  logic [AW-1:0]           coef_addr = '0;
  logic signed [8:0]       coef_data = '0;
  logic                    coef_err;
  logic signed [3:0]       mul_in;
  logic signed [8:0]       mul_h;
  logic signed [15:0]      mul_prod;
  logic                    out_valid;
  logic signed [ACC_W-1:0] out_data;
  logic                    out_ready = 1'b0;

  always #5 clk = ~clk;

  assign mul_prod = $signed(mul_in) * $signed(mul_h);

  fir_mac_ctrl #(.NTAPS(NTAPS), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_err(coef_err),
    .mul_in(mul_in), .mul_h(mul_h), .mul_prod(mul_prod),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // model: history/coefs as plain ints, pass tracked as phase + cycle count
  int hist [NTAPS];
  int mc   [NTAPS];
  int phase;
  int cnt;
  int res;
  bit e_valid;
  int e_data;
  bit e_err;

  task automatic chk(string n, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", n, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NTAPS; k++) begin
      hist[k] = 0;
      mc[k] = 0;
    end
    phase = 0;
    cnt = 0;
    res = 0;
    e_valid = 1'b0;
    e_data = 0;
    e_err = 1'b0;
  endtask

  task automatic model_step();
    e_err = coef_we && (phase != 0);
    case (phase)
      0: begin
        if (coef_we)
          mc[coef_addr] = int'(coef_data);
        if (in_valid) begin
          for (int k = NTAPS - 1; k > 0; k--)
            hist[k] = hist[k-1];
          hist[0] = int'(in_data);
          res = 0;
          for (int k = 0; k < NTAPS; k++)
            res += hist[k] * mc[k];
          cnt = 0;
          phase = 1;
        end
      end
      1: begin
        cnt++;
        if (cnt == NTAPS) begin
          cnt = 0;
          phase = 2;
          e_valid = 1'b1;
          e_data = res;
        end
      end
      default: begin
        if (out_ready) begin
          e_valid = 1'b0;
          phase = 0;
        end
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", int'(in_ready), int'(phase == 0));
      chk("out_valid", int'(out_valid), int'(e_valid));
      chk("out_data", int'(out_data), e_data);
      chk("coef_err", int'(coef_err), int'(e_err));
      chk("mul_in", int'(mul_in), (phase == 1) ? hist[cnt] : 0);
      chk("mul_h", int'(mul_h), (phase == 1) ? mc[cnt] : 0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    if (rst_n)
      model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic wr_coef(int a, int d);
    coef_we = 1'b1;
    coef_addr = AW'(a);
    coef_data = 9'(d);
    cyc();
    coef_we = 1'b0;
  endtask

  task automatic run_sample(int s, bit do_lit, int lit, string n);
    in_valid = 1'b1;
    in_data = 4'(s);
    cyc();
    in_valid = 1'b0;
    repeat (NTAPS) cyc();
    chk({n, "_valid"}, int'(out_valid), 1);
    if (do_lit) begin
      chk({n, "_model"}, e_data, lit);
      chk({n, "_dut"}, int'(out_data), lit);
    end
    cyc();
  endtask

  initial begin
    model_reset();
    chk_en = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // impulse response through coef k+1
    for (int k = 0; k < NTAPS; k++)
      wr_coef(k, k + 1);
    for (int i = 0; i < NTAPS; i++)
      run_sample((i == 0) ? 1 : 0, 1'b1, i + 1, "impulse");

    // extreme operands
    for (int k = 0; k < NTAPS; k++)
      wr_coef(k, -256);
    for (int i = 0; i < NTAPS; i++)
      run_sample(-8, i == NTAPS - 1, 16384, "max_pos");
    for (int i = 0; i < NTAPS; i++)
      run_sample(7, i == NTAPS - 1, -14336, "max_neg");

    // backpressure in DONE
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 4'(3);
    cyc();
    in_valid = 1'b0;
    repeat (NTAPS) cyc();
    chk("bp_model", e_data, -13312);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = 4'($urandom_range(0, 15));
      cyc();
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_hold", int'(out_data), -13312);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc();
    chk("bp_release_valid", int'(out_valid), 0);
    chk("bp_release_ready", int'(in_ready), 1);

    // rejected write during MAC
    in_valid = 1'b1;
    in_data = 4'(1);
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    wr_coef(3, 100);
    chk("werr_pulse", int'(coef_err), 1);
    cyc();
    chk("werr_clear", int'(coef_err), 0);
    repeat (NTAPS - 4) cyc();
    chk("werr_result", int'(out_data), -11776);
    cyc();
    run_sample(0, 1'b1, -9984, "werr_coef_kept");

    // reset mid-MAC
    in_valid = 1'b1;
    in_data = 4'(5);
    cyc();
    in_valid = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("abort_mul_in", int'(mul_in), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    cyc();
    rst_n = 1'b1;
    run_sample(4, 1'b1, 0, "post_reset");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = 4'($urandom_range(0, 15));
      coef_we = ($urandom_range(0, 5) == 0);
      coef_addr = AW'($urandom_range(0, NTAPS - 1));
      coef_data = 9'($urandom_range(0, 511));
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    coef_we = 1'b0;
    in_valid = 1'b0;

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
